sram_input_loader: RTL and testbench

Upstream stage of the SRAM-based DUT. Accepts a valid/ready stream of 16-bit words and writes them sequentially into the input SRAM from a programmable base address. After the last word it pulses `dut_run` and holds `loader_busy` until the DUT's `dut_busy` handshake completes. A small FIFO absorbs cycles where the shared SRAM write port is not granted.

---
 rtl/loader_pkg.sv | 16 +
 rtl/loader_fifo.sv | 62 ++++++
 rtl/sram_input_loader.sv | 150 +++++++++++++++
 tb/tb_sram_input_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared state encoding and default widths for the SRAM input loader.
// Used by sram_input_loader and loader_fifo.
package loader_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KICK = 3'd2,
    ACK  = 3'd3,
    RUN  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO that buffers accepted words while the shared SRAM
// write port is not granted. DEPTH must be a power of two, at least 2.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/sram_input_loader.sv
// Streams words into the input SRAM from a base address, then starts the DUT
// and waits for its busy handshake. Optional running checksum: LOADER_CHECKSUM_EN.
module sram_input_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = loader_pkg::ADDR_W,
  parameter int DATA_W     = loader_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              sram_wr_grant,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_addr,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic              loader_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_LOAD = LOAD;
  localparam logic [2:0] ST_KICK = KICK;
  localparam logic [2:0] ST_ACK  = ACK;
  localparam logic [2:0] ST_RUN  = RUN;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] acc_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              start_ok;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              load_finished;

  assign start_ok    = (state == ST_IDLE) && load_start && (load_len != '0);
  assign in_ready    = (state == ST_LOAD) && !fifo_full && (acc_cnt < len_q);
  assign push        = in_valid && in_ready;
  assign pop         = !fifo_empty && sram_wr_grant;
  assign loader_busy = (state != ST_IDLE);
  assign dut_run     = (state == ST_KICK);

  // The last word must have left the output register before the DUT is kicked.
  assign load_finished = (acc_cnt == len_q) && fifo_empty && !dut_sram_write_enable;

  loader_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok)      state_nxt = ST_LOAD;
      ST_LOAD: if (load_finished) state_nxt = ST_KICK;
      ST_KICK:                    state_nxt = ST_ACK;
      ST_ACK:  if (dut_busy)      state_nxt = ST_RUN;
      ST_RUN:  if (!dut_busy)     state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= ST_IDLE;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= (state == ST_RUN) && !dut_busy;
      load_err  <= (state == ST_IDLE) && load_start && (load_len == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      len_q   <= '0;
      acc_cnt <= '0;
      wr_addr <= '0;
    end else if (start_ok) begin
      len_q   <= load_len;
      acc_cnt <= '0;
      wr_addr <= base_addr;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + ADDR_W'(1);
      end
      // Address wraps naturally at 2^ADDR_W.
      if (pop) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dut_sram_write_enable <= 1'b0;
      dut_sram_write_addr   <= '0;
      dut_sram_write_data   <= '0;
    end else begin
      dut_sram_write_enable <= pop;
      if (pop) begin
        dut_sram_write_addr <= wr_addr;
        dut_sram_write_data <= fifo_rd_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Sum is taken at the pop, so it covers exactly the words that get written.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + fifo_rd_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sram_input_loader.sv
// Randomized bench for sram_input_loader with a queue-based reference model;
// checksum expectations follow LOADER_CHECKSUM_EN.
module tb_sram_input_loader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_len = '0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          sram_wr_grant = 1'b0;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_sram_write_addr;
  logic [DW-1:0] dut_sram_write_data;
  logic          dut_run;
  logic          dut_busy = 1'b0;
  logic          loader_busy;
  logic          load_done;
  logic          load_err;
  logic [DW-1:0] checksum;

  int totalCount = 0;
  int badCount = 0;

  logic [DW-1:0] words[$];
  int            expLen = 0;
  logic [AW-1:0] expBase = '0;
  bit            active = 1'b0;
  bit            checkLatency = 1'b0;
  bit            grantRand = 1'b0;
  int            lowFrom = 0;
  int            lowLen = 0;
  int            accStart = 0;
  int            writeStart = 0;
  int            runStart = 0;
  int            doneStart = 0;
  int            errStart = 0;

  int cycle = 0;
  int accTotal = 0;
  int writeTotal = 0;
  int runTotal = 0;
  int doneTotal = 0;
  int errTotal = 0;
  int acceptEdge [0:63];

  sram_input_loader dut (
    .clk                   (clk),
    .reset_b               (reset_b),
    .load_start            (load_start),
    .load_len              (load_len),
    .base_addr             (base_addr),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .sram_wr_grant         (sram_wr_grant),
    .dut_sram_write_enable (dut_sram_write_enable),
    .dut_sram_write_addr   (dut_sram_write_addr),
    .dut_sram_write_data   (dut_sram_write_data),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .loader_busy           (loader_busy),
    .load_done             (load_done),
    .load_err              (load_err),
    .checksum              (checksum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Address of the k-th word of the current load, modulo the SRAM size.
  function automatic logic [AW-1:0] expAddr(input int k);
    return expBase + AW'(k);
  endfunction

  function automatic logic [DW-1:0] expChecksum(input logic [DW-1:0] sum);
`ifdef LOADER_CHECKSUM_EN
    return sum;
`else
    return '0;
`endif
  endfunction

  // Handshake sampling and stray-ready detection on the active edge.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (in_valid && in_ready) begin
      accTotal <= accTotal + 1;
      if (accTotal - accStart < 64) acceptEdge[accTotal - accStart] <= cycle + 1;
    end
    if (active && in_ready && (accTotal - accStart >= expLen))
      checkOutput("readyAfterLast", in_ready, 1'b0);
  end

  // Output scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (dut_sram_write_enable) begin
      writeTotal <= writeTotal + 1;
      if (!active) begin
        checkOutput("strayWrite", dut_sram_write_enable, 1'b0);
      end else if (writeTotal - writeStart < expLen) begin
        checkOutput("writeAddr", dut_sram_write_addr, expAddr(writeTotal - writeStart));
        checkOutput("writeData", dut_sram_write_data, words[writeTotal - writeStart]);
        if (checkLatency && (writeTotal - writeStart < 64))
          checkOutput("latency", cycle - acceptEdge[writeTotal - writeStart], 1);
      end else begin
        checkOutput("writeCount", writeTotal - writeStart + 1, expLen);
      end
    end
    if (dut_run) begin
      runTotal <= runTotal + 1;
      if (active) begin
        checkOutput("runAfterWrites", writeTotal - writeStart, expLen);
        checkOutput("runNoWrite", dut_sram_write_enable, 1'b0);
      end else begin
        checkOutput("strayRun", dut_run, 1'b0);
      end
    end
    if (load_done) doneTotal <= doneTotal + 1;
    if (load_err) errTotal <= errTotal + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if ((cycle >= lowFrom) && (cycle - lowFrom < lowLen)) sram_wr_grant = 1'b0;
      else if (grantRand) sram_wr_grant = 1'($urandom_range(0, 1));
      else sram_wr_grant = 1'b1;
    end
  end

  task automatic checkIdleOutputs(input string p);
    checkOutput({p, "InReady"}, in_ready, 1'b0);
    checkOutput({p, "WrEn"}, dut_sram_write_enable, 1'b0);
    checkOutput({p, "WrAddr"}, dut_sram_write_addr, '0);
    checkOutput({p, "WrData"}, dut_sram_write_data, '0);
    checkOutput({p, "Run"}, dut_run, 1'b0);
    checkOutput({p, "Busy"}, loader_busy, 1'b0);
    checkOutput({p, "Done"}, load_done, 1'b0);
    checkOutput({p, "Err"}, load_err, 1'b0);
    checkOutput({p, "Checksum"}, checksum, '0);
  endtask

  // wordMode: 0 = 0xA000+i, 1 = random, 2 = {0xFFFF, 0x0002}.
  // abortAfter >= 0 asserts reset once that many words have been accepted.
  task automatic applyStimulus(input int len, input logic [AW-1:0] b, input int wordMode,
                               input bit randValid, input bit randGrant, input int lowCycles,
                               input bit busyEarly, input bit latChk, input int abortAfter);
    logic [DW-1:0] w;
    logic [DW-1:0] sum;
    int            guard;
    int            acc;
    bit            injected;
    words.delete();
    sum = '0;
    for (int i = 0; i < len; i++) begin
      if (wordMode == 0) w = 16'hA000 + DW'(i);
      else if (wordMode == 2) w = (i == 0) ? 16'hFFFF : 16'h0002;
      else w = DW'($urandom);
      words.push_back(w);
      sum = sum + w;
    end
    @(negedge clk);
    expLen = len;
    expBase = b;
    checkLatency = latChk;
    grantRand = randGrant;
    accStart = accTotal;
    writeStart = writeTotal;
    runStart = runTotal;
    doneStart = doneTotal;
    errStart = errTotal;
    lowFrom = cycle;
    lowLen = lowCycles;
    load_len = AW'(len);
    base_addr = b;
    load_start = 1'b1;
    active = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_len = AW'($urandom);
    base_addr = AW'($urandom);
    checkOutput("busyAfterStart", loader_busy, 1'b1);
    guard = 0;
    injected = 1'b0;
    acc = 0;
    while (acc < len && guard < 2000) begin
      if (abortAfter >= 0 && acc >= abortAfter) break;
      if (lowCycles >= 10 && guard == 8) begin
        checkOutput("bpAccepted", acc, 4);
        checkOutput("bpReady", in_ready, 1'b0);
      end
      in_data = words[acc];
      in_valid = randValid ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (acc == 1 && !injected) begin
        load_start = 1'b1;
        load_len = '0;
        injected = 1'b1;
      end else begin
        load_start = 1'b0;
      end
      @(negedge clk);
      guard++;
      acc = accTotal - accStart;
    end
    in_valid = 1'b0;
    load_start = 1'b0;

    if (abortAfter >= 0) begin
      checkOutput("abortReached", acc, abortAfter);
      reset_b = 1'b0;
      #1;
      checkIdleOutputs("midReset");
      active = 1'b0;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("noRunAfterReset", runTotal - runStart, 0);
      checkOutput("idleAfterReset", loader_busy, 1'b0);
      return;
    end

    checkOutput("acceptedAll", acc, len);
    if (busyEarly) dut_busy = 1'b1;
    guard = 0;
    while (!dut_run && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("runSeen", dut_run, 1'b1);
    @(negedge clk);
    checkOutput("runPulseEnd", dut_run, 1'b0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    dut_busy = 1'b1;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    checkOutput("busyWhileRun", loader_busy, 1'b1);
    checkOutput("noEarlyDone", doneTotal - doneStart, 0);
    dut_busy = 1'b0;
    guard = 0;
    while (!load_done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("doneSeen", load_done, 1'b1);
    checkOutput("idleOnDone", loader_busy, 1'b0);
    @(negedge clk);
    checkOutput("donePulseEnd", load_done, 1'b0);
    checkOutput("runCount", runTotal - runStart, 1);
    checkOutput("doneCount", doneTotal - doneStart, 1);
    checkOutput("writesTotal", writeTotal - writeStart, len);
    checkOutput("ignoredStart", errTotal - errStart, 0);
    checkOutput("checksum", checksum, expChecksum(sum));
    repeat (2) @(negedge clk);
    checkOutput("checksumHold", checksum, expChecksum(sum));
    active = 1'b0;
  endtask

  task automatic zeroLength();
    @(negedge clk);
    errStart = errTotal;
    writeStart = writeTotal;
    load_len = '0;
    base_addr = 12'h055;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checkOutput("errPulse", load_err, 1'b1);
    checkOutput("errBusy", loader_busy, 1'b0);
    @(negedge clk);
    checkOutput("errOneCycle", load_err, 1'b0);
    checkOutput("errIdle", loader_busy, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("errCount", errTotal - errStart, 1);
    checkOutput("errNoWrites", writeTotal - writeStart, 0);
  endtask

  initial begin
    $display("[TB] starting sram_input_loader bench");
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset_b = 1'b1;
    @(negedge clk);
    checkIdleOutputs("postReset");

    applyStimulus(3, 12'h010, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, -1);
    applyStimulus(4, 12'hFFE, 1, 1'b0, 1'b0, 0, 1'b0, 1'b1, -1);
    applyStimulus(6, 12'h123, 1, 1'b0, 1'b0, 10, 1'b0, 1'b0, -1);
    zeroLength();
    applyStimulus(2, 12'h200, 2, 1'b0, 1'b0, 0, 1'b1, 1'b1, -1);
    for (int i = 0; i < 12; i++)
      applyStimulus($urandom_range(1, 24), AW'($urandom), 1, 1'b1, 1'b1, 0, 1'(i % 2), 1'b0, -1);
    applyStimulus(40, 12'hFF0, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0, -1);
    applyStimulus(5, 12'h300, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2);
    applyStimulus(3, 12'h7FF, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
